ad7928_emu: RTL and testbench



---
 rtl/ad7928_pkg.sv | 43 ++++
 rtl/ad7928_emu_sync.sv | 58 +++++
 rtl/ad7928_emu.sv | 185 ++++++++++++++++++
 tb/tb_ad7928_emu.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ad7928_pkg.sv
// Shared constants, DIN field positions and FSM state type for the AD7928 SPI responder.
// Related build option: AD7928_EMU_CODING_EN selects honouring of the CODING bit.
package ad7928_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = 5;
    localparam int VALUE_W    = 12;
    localparam int CTRL_W     = 12;
    localparam int ADDR_W     = 3;

    localparam int DIN_WRITE  = 15;
    localparam int DIN_SEQ    = 14;
    localparam int DIN_ADD_HI = 12;
    localparam int DIN_ADD_LO = 10;
    localparam int DIN_PM_HI  = 9;
    localparam int DIN_PM_LO  = 8;
    localparam int DIN_SHADOW = 7;
    localparam int DIN_RANGE  = 5;
    localparam int DIN_CODING = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } ad7928_emu_state_t;

    // DOUT word: leading zero, channel address, conversion code.
    function automatic logic [FRAME_BITS-1:0] frame_word(
        input logic [ADDR_W-1:0]  addr,
        input logic [VALUE_W-1:0] value
    );
        return {1'b0, addr, value};
    endfunction

    // CODING=0 selects two's complement: only the MSB of the straight code flips.
    function automatic logic [VALUE_W-1:0] apply_coding(
        input logic [VALUE_W-1:0] value,
        input logic               coding
    );
        return coding ? value : {~value[VALUE_W-1], value[VALUE_W-2:0]};
    endfunction

endpackage

// File: rtl/ad7928_emu_sync.sv
// 2-FF synchronizer for the asynchronous SPI pins plus edge pulses on ss and sck.
// Edge pulses are held off for three cycles after reset so a bus already low is not seen as a new frame.
module ad7928_emu_sync (
    input  logic clk,
    input  logic rst,
    input  logic spi_ss,
    input  logic spi_sck,
    input  logic spi_mosi,
    output logic ss_s,
    output logic sck_s,
    output logic mosi_s,
    output logic ss_fall,
    output logic ss_rise,
    output logic sck_fall
);

    logic [2:0] meta_q, meta_d;
    logic [2:0] sync_q, sync_d;
    logic [1:0] prev_q, prev_d;
    logic [1:0] flush_q, flush_d;
    logic       armed;

    always_comb begin
        meta_d  = {spi_ss, spi_sck, spi_mosi};
        sync_d  = meta_q;
        prev_d  = sync_q[2:1];
        flush_d = flush_q;
        if (flush_q != 2'd3) begin
            flush_d = flush_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 3'b111;
            sync_q  <= 3'b111;
            prev_q  <= 2'b11;
            flush_q <= 2'd0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            flush_q <= flush_d;
        end
    end

    // prev_q only tracks real pin history once the reset fill has drained out.
    assign armed    = (flush_q == 2'd3);

    assign ss_s     = sync_q[2];
    assign sck_s    = sync_q[1];
    assign mosi_s   = sync_q[0];

    assign ss_fall  = armed &  prev_q[1] & ~sync_q[2];
    assign ss_rise  = armed & ~prev_q[1] &  sync_q[2];
    assign sck_fall = armed &  prev_q[0] & ~sync_q[1];

endmodule

// File: rtl/ad7928_emu.sv
// SPI responder emulating an AD7928: each frame returns the channel addressed by the previous frame.
// Define AD7928_EMU_CODING_EN to honour the CODING bit (two's complement output when CODING=0).
module ad7928_emu #(
    parameter int OVS_MIN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_ss,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [11:0] i_adc_value0,
    input  logic [11:0] i_adc_value1,
    input  logic [11:0] i_adc_value2,
    input  logic [11:0] i_adc_value3,
    input  logic [11:0] i_adc_value4,
    input  logic [11:0] i_adc_value5,
    input  logic [11:0] i_adc_value6,
    input  logic [11:0] i_adc_value7,
    output logic        o_frame_done,
    output logic        o_frame_err,
    output logic [11:0] o_ctrl,
    output logic [2:0]  o_addr
);

    import ad7928_pkg::*;

    logic ss_s;
    logic sck_s;
    logic mosi_s;
    logic ss_fall;
    logic ss_rise;
    logic sck_fall;

    ad7928_emu_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .spi_ss   (spi_ss),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .ss_s     (ss_s),
        .sck_s    (sck_s),
        .mosi_s   (mosi_s),
        .ss_fall  (ss_fall),
        .ss_rise  (ss_rise),
        .sck_fall (sck_fall)
    );

    ad7928_emu_state_t      state_q, state_d;
    logic [FRAME_BITS-1:0]  tx_q, tx_d;
    logic [FRAME_BITS-1:0]  rx_q, rx_d;
    logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
    logic                   miso_q, miso_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [VALUE_W-1:0]     sel_value;
    logic [VALUE_W-1:0]     load_value;
    logic                   frame_full;

    always_comb begin
        sel_value = i_adc_value0;
        case (addr_q)
            3'd0: sel_value = i_adc_value0;
            3'd1: sel_value = i_adc_value1;
            3'd2: sel_value = i_adc_value2;
            3'd3: sel_value = i_adc_value3;
            3'd4: sel_value = i_adc_value4;
            3'd5: sel_value = i_adc_value5;
            3'd6: sel_value = i_adc_value6;
            3'd7: sel_value = i_adc_value7;
            default: sel_value = i_adc_value0;
        endcase
    end

`ifdef AD7928_EMU_CODING_EN
    always_comb begin
        load_value = apply_coding(sel_value, ctrl_q[DIN_CODING-DIN_CODING]);
    end
`else
    always_comb begin
        load_value = sel_value;
    end
`endif

    assign frame_full = (bitcnt_q == CNT_W'(FRAME_BITS));

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        bitcnt_d = bitcnt_q;
        addr_d   = addr_q;
        ctrl_d   = ctrl_q;
        miso_d   = miso_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                miso_d = 1'b1;
                if (ss_fall) begin
                    // Track/hold: the channel code is captured here and never re-read this frame.
                    tx_d     = frame_word(addr_q, load_value);
                    rx_d     = '0;
                    bitcnt_d = '0;
                    miso_d   = tx_d[FRAME_BITS-1];
                    state_d  = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (ss_rise) begin
                    miso_d  = 1'b1;
                    state_d = ST_DONE;
                    if (frame_full) begin
                        done_d = 1'b1;
                        if (rx_q[DIN_WRITE]) begin
                            ctrl_d = rx_q[DIN_WRITE:DIN_CODING];
                            addr_d = rx_q[DIN_ADD_HI:DIN_ADD_LO];
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (!frame_full) begin
                        rx_d     = {rx_q[FRAME_BITS-2:0], mosi_s};
                        tx_d     = {tx_q[FRAME_BITS-2:0], 1'b0};
                        bitcnt_d = bitcnt_q + CNT_W'(1);
                        miso_d   = tx_d[FRAME_BITS-1];
                    end else begin
                        miso_d = 1'b0;
                    end
                end
            end

            ST_DONE: begin
                miso_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                miso_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tx_q     <= '0;
            rx_q     <= '0;
            bitcnt_q <= '0;
            addr_q   <= '0;
            ctrl_q   <= '0;
            miso_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            bitcnt_q <= bitcnt_d;
            addr_q   <= addr_d;
            ctrl_q   <= ctrl_d;
            miso_q   <= miso_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign spi_miso     = miso_q;
    assign o_frame_done = done_q;
    assign o_frame_err  = err_q;
    assign o_ctrl       = ctrl_q;
    assign o_addr       = addr_q;

    // Levels, the shifted-out MSB and the oversampling figure are informational only.
    logic unused_sigs;
    assign unused_sigs = ss_s ^ sck_s ^ tx_q[FRAME_BITS-1] ^ (OVS_MIN > 0);

endmodule

// File: tb/tb_ad7928_emu.sv
// Bench for ad7928_emu: SPI master tasks, a frame-level model of the chip and a per-cycle compare process.
// Honours AD7928_EMU_CODING_EN in the model so either build can be checked.
module tb_ad7928_emu;

    localparam int W = 17;  // {err, done, ctrl[11:0], addr[2:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_ss = 1'b1;
    logic        spi_sck = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        o_frame_done;
    logic        o_frame_err;
    logic [11:0] o_ctrl;
    logic [2:0]  o_addr;
    logic [11:0] adc [8];

    ad7928_emu #(.OVS_MIN(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_ss       (spi_ss),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .i_adc_value0 (adc[0]),
        .i_adc_value1 (adc[1]),
        .i_adc_value2 (adc[2]),
        .i_adc_value3 (adc[3]),
        .i_adc_value4 (adc[4]),
        .i_adc_value5 (adc[5]),
        .i_adc_value6 (adc[6]),
        .i_adc_value7 (adc[7]),
        .o_frame_done (o_frame_done),
        .o_frame_err  (o_frame_err),
        .o_ctrl       (o_ctrl),
        .o_addr       (o_addr)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_e;
    logic [11:0] m_ctrl = 12'h000;   // chip state as the frame sequence defines it
    logic [2:0]  m_addr = 3'd0;
    logic [11:0] c_ctrl = 12'h000;   // state the outputs must show right now
    logic [2:0]  c_addr = 3'd0;
    logic        rst_seen = 1'b1;
    int          half = 4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare process: frame-end pulses against the expected queue, held ctrl/addr every cycle.
    always @(posedge clk) rst_seen <= rst;

    always @(negedge clk) begin
        if (rst_seen) begin
            exp_q.delete();
            c_ctrl = 12'h000;
            c_addr = 3'd0;
            check("reset_miso", spi_miso, 1);
            check("reset_pulses", {o_frame_err, o_frame_done}, 0);
        end else if (o_frame_done || o_frame_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {o_frame_err, o_frame_done}, 0);
            end else begin
                exp_e = exp_q.pop_front();
                check("frame_end", {o_frame_err, o_frame_done, o_ctrl, o_addr}, 32'(exp_e));
                c_ctrl = exp_e[14:3];
                c_addr = exp_e[2:0];
            end
        end
        check("ctrl_hold", o_ctrl, c_ctrl);
        check("addr_hold", o_addr, c_addr);
    end

    // One master frame of nbits SCK periods; returns received bits (LSB = last) and the model DOUT word.
    task automatic frame(input logic [15:0] din, input int nbits, input bit chg_mid,
                         output logic [31:0] got, output logic [15:0] expw);
        logic [11:0] v;
        v = adc[m_addr];
`ifdef AD7928_EMU_CODING_EN
        if (!m_ctrl[0]) v[11] = ~v[11];
`endif
        expw = {1'b0, m_addr, v};
        got  = 32'h0;
        half = $urandom_range(4, 6);
        spi_ss = 1'b0;
        tick(6);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 16) ? din[15-i] : 1'($urandom);
            tick(half);
            got = {got[30:0], spi_miso};
            spi_sck = 1'b0;
            tick(half);
            spi_sck = 1'b1;
            if (chg_mid && i == 4) adc[m_addr] = 12'($urandom);
        end
        tick(half);
        spi_ss = 1'b1;
        if (nbits >= 16) begin
            if (din[15]) begin
                m_ctrl = din[15:4];
                m_addr = din[12:10];
            end
            exp_q.push_back({1'b0, 1'b1, m_ctrl, m_addr});
        end else begin
            exp_q.push_back({1'b1, 1'b0, m_ctrl, m_addr});
        end
        tick($urandom_range(4, 10));
        check("idle_miso", spi_miso, 1);
    endtask

    task automatic run(input logic [15:0] din, input int nbits, input bit chg_mid,
                       output logic [31:0] got);
        logic [15:0] expw;
        logic [31:0] want;
        frame(din, nbits, chg_mid, got, expw);
        if (nbits >= 16) want = 32'(expw) << (nbits - 16);
        else             want = 32'(expw) >> (16 - nbits);
        check("dout", got, want);
    endtask

    // Frame abandoned by reset; ss stays low across release and must not start a frame.
    task automatic abort_by_reset();
        spi_ss = 1'b0;
        tick(6);
        for (int i = 0; i < 5; i++) begin
            spi_mosi = 1'($urandom);
            tick(4); spi_sck = 1'b0; tick(4); spi_sck = 1'b1;
        end
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        m_ctrl = 12'h000;
        m_addr = 3'd0;
        tick(4);
        check("rst_addr", o_addr, 0);
        for (int i = 0; i < 3; i++) begin
            tick(4); spi_sck = 1'b0; tick(4); spi_sck = 1'b1;
            check("rst_idle_miso", spi_miso, 1);
        end
        tick(4);
        spi_ss = 1'b1;
        tick(10);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not complete");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        int          r;
        for (int i = 0; i < 8; i++) adc[i] = 12'($urandom);
        adc[0] = 12'h123;
        adc[5] = 12'hABC;
        rst = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(6);
        check("init_addr", o_addr, 0);
        check("init_ctrl", o_ctrl, 0);
        check("init_miso", spi_miso, 1);

        // Address pipeline
        run(16'h8330, 16, 1'b0, got);
`ifdef AD7928_EMU_CODING_EN
        check("tp1_f1", got, 32'h0923);
`else
        check("tp1_f1", got, 32'h0123);
`endif
        run(16'h9730, 16, 1'b0, got);
        check("tp1_f2", got, 32'h0123);
        check("tp1_addr5", o_addr, 5);
        check("tp1_ctrl", o_ctrl, 12'h973);

        // WRITE=0 keeps ctrl/addr
        run(16'h1F00, 16, 1'b0, got);
        check("tp1_f3", got, 32'h5ABC);
        check("tp3_ctrl", o_ctrl, 12'h973);
        check("tp3_addr", o_addr, 5);

        // Short frame
        run(16'h8C30, 9, 1'b0, got);
        check("tp2_bits", got, 32'h0B5);
        check("tp2_addr", o_addr, 5);
        check("tp2_ctrl", o_ctrl, 12'h973);
        run(16'h8320, 16, 1'b0, got);
        check("tp2_next", got, 32'h5ABC);

        // Coding: previous frame wrote CODING=0
        adc[0] = 12'h123;
        run(16'h8330, 16, 1'b0, got);
`ifdef AD7928_EMU_CODING_EN
        check("tp4_coding", got, 32'h0923);
`else
        check("tp4_coding", got, 32'h0123);
`endif

        // Hold: channel 0 changes mid-frame
        run(16'h8330, 16, 1'b1, got);
        check("tp5_hold", got, 32'h0123);
        run(16'h8330, 18, 1'b0, got);

        abort_by_reset();
        check("tp5_addr0", o_addr, 0);
        run(16'hA730, 16, 1'b0, got);

        for (int n = 0; n < 110; n++) begin
            if ($urandom_range(0, 3) == 0) adc[$urandom_range(0, 7)] = 12'($urandom);
            r = $urandom_range(0, 19);
            if (r == 0) begin
                abort_by_reset();
            end else if (r < 3) begin
                run(16'($urandom), $urandom_range(1, 15), 1'($urandom), got);
            end else if (r < 5) begin
                run(16'($urandom), $urandom_range(17, 18), 1'($urandom), got);
            end else begin
                run(16'($urandom), 16, 1'($urandom), got);
            end
        end

        tick(10);
        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
